// File: rtl/jtroc_sdram_arb_if.sv
// Requester and SDRAM read-port bundle shared by the Roc'n Rope ROM arbiter.
// The slave side is the arbiter; the master side drives requests and the SDRAM responses.
interface jtroc_sdram_arb_if;
    logic [3:0]  slot_cs;
    logic [63:0] slot_addr;
    logic [3:0]  slot_ok;
    logic [63:0] slot_dout;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_rdy;
    logic [15:0] data_read;

    modport slave (
        input  slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
        output slot_ok, slot_dout, sdram_req, sdram_addr
    );

    modport master (
        output slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
        input  slot_ok, slot_dout, sdram_req, sdram_addr
    );
endinterface

// File: rtl/jtroc_sdram_arb.sv
// Fixed-priority four-slot SDRAM read arbiter with a one-word tag/data cache per slot.
//   state     | meaning
//   IDLE      | no transaction; pick lowest-numbered missing slot
//   WAIT_ACK  | sdram_req held until the controller acknowledges
//   WAIT_DATA | request accepted, waiting for data_rdy to fill the slot
module jtroc_sdram_arb #(
    parameter logic [21:0] SLOT0_OFFSET = 22'h0,
    parameter logic [21:0] SLOT1_OFFSET = 22'h0,
    parameter logic [21:0] SLOT2_OFFSET = 22'h0,
    parameter logic [21:0] SLOT3_OFFSET = 22'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               downloading,
    jtroc_sdram_arb_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

    state_t          state;
    logic [3:0]      valid;
    logic [3:0][15:0] tag;
    logic [3:0][15:0] data;
    logic [1:0]      win;
    logic [15:0]     tag_req;
    logic            req;
    logic [21:0]     addr;

    logic [3:0]      hit;
    logic [3:0]      miss;
    logic [1:0]      pick;
    logic [15:0]     pick_addr;
    logic [21:0]     pick_offset;
    logic            fill;

    always_comb begin
        hit = '0;
        for (int n = 0; n < 4; n++)
            hit[n] = valid[n] && (tag[n] == bus.slot_addr[16*n +: 16]);
        miss = bus.slot_cs & ~hit;
        pick = 2'd3;
        for (int n = 3; n >= 0; n--)
            if (miss[n]) pick = 2'(n);
        pick_addr = bus.slot_addr[{pick, 4'b0000} +: 16];
        case (pick)
            2'd0:    pick_offset = SLOT0_OFFSET;
            2'd1:    pick_offset = SLOT1_OFFSET;
            2'd2:    pick_offset = SLOT2_OFFSET;
            default: pick_offset = SLOT3_OFFSET;
        endcase
        // An ack and data arriving together in WAIT_ACK count as a completed fill
        fill = bus.data_rdy && ((state == WAIT_DATA) || (state == WAIT_ACK && bus.sdram_ack));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            req     <= 1'b0;
            addr    <= '0;
            valid   <= '0;
            tag     <= '0;
            data    <= '0;
            win     <= '0;
            tag_req <= '0;
        end else if (downloading) begin
            state <= IDLE;
            req   <= 1'b0;
            valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|miss) begin
                        win     <= pick;
                        tag_req <= pick_addr;
                        addr    <= pick_offset + {6'b0, pick_addr};
                        req     <= 1'b1;
                        state   <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (bus.sdram_ack) begin
                        req   <= 1'b0;
                        state <= fill ? IDLE : WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (fill) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (fill) begin
                data[win]  <= bus.data_read;
                tag[win]   <= tag_req;
                valid[win] <= 1'b1;
            end
        end
    end

    assign bus.slot_ok    = bus.slot_cs & hit;
    assign bus.slot_dout  = data;
    assign bus.sdram_req  = req;
    assign bus.sdram_addr = addr;

endmodule

// File: tb/tb_jtroc_sdram_arb.sv
// Directed bench for jtroc_sdram_arb: transaction-level cache/arbiter model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_jtroc_sdram_arb;

    localparam logic [21:0] OFF0 = 22'h0;
    localparam logic [21:0] OFF1 = 22'h010000;
    localparam logic [21:0] OFF2 = 22'h3FFFF0;
    localparam logic [21:0] OFF3 = 22'h0;

    logic clk = 1'b0;
    logic rst;
    logic downloading;

    jtroc_sdram_arb_if bus();

    jtroc_sdram_arb #(
        .SLOT0_OFFSET(OFF0),
        .SLOT1_OFFSET(OFF1),
        .SLOT2_OFFSET(OFF2),
        .SLOT3_OFFSET(OFF3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .downloading(downloading),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: cache contents plus at most one outstanding transaction record
    logic [3:0]  m_valid;
    logic [15:0] m_tag  [4];
    logic [15:0] m_data [4];
    bit          m_busy;
    bit          m_acked;
    bit          m_req;
    int          m_win;
    logic [15:0] m_treq;
    logic [21:0] m_addr;

    function automatic logic [21:0] offset_of(int s);
        case (s)
            0:       return OFF0;
            1:       return OFF1;
            2:       return OFF2;
            default: return OFF3;
        endcase
    endfunction

    function automatic logic [15:0] addr_of(int s);
        return bus.slot_addr[16*s +: 16];
    endfunction

    function automatic logic [3:0] exp_ok();
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++)
            r[i] = bus.slot_cs[i] && m_valid[i] && (m_tag[i] == addr_of(i));
        return r;
    endfunction

    task automatic model_edge();
        int  first;
        bit  fill;
        if (rst) begin
            m_valid = '0;
            for (int i = 0; i < 4; i++) begin
                m_tag[i]  = '0;
                m_data[i] = '0;
            end
            m_busy = 0; m_acked = 0; m_req = 0; m_addr = '0;
        end else if (downloading) begin
            m_valid = '0;
            m_busy  = 0;
            m_req   = 0;
        end else if (!m_busy) begin
            first = -1;
            for (int i = 3; i >= 0; i--)
                if (bus.slot_cs[i] && !(m_valid[i] && m_tag[i] == addr_of(i))) first = i;
            if (first >= 0) begin
                m_busy  = 1;
                m_acked = 0;
                m_req   = 1;
                m_win   = first;
                m_treq  = addr_of(first);
                m_addr  = offset_of(first) + {6'b0, m_treq};
            end
        end else begin
            fill = bus.data_rdy && (m_acked || bus.sdram_ack);
            if (!m_acked && bus.sdram_ack) begin
                m_req   = 0;
                m_acked = 1;
            end
            if (fill) begin
                m_data[m_win]  = bus.data_read;
                m_tag[m_win]   = m_treq;
                m_valid[m_win] = 1'b1;
                m_busy         = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("model_slot_ok", 64'(bus.slot_ok), 64'(exp_ok()));
        chk("model_slot_dout", bus.slot_dout, {m_data[3], m_data[2], m_data[1], m_data[0]});
        chk("model_sdram_req", 64'(bus.sdram_req), 64'(m_req));
        if (m_req) chk("model_sdram_addr", 64'(bus.sdram_addr), 64'(m_addr));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_now();
        #1;
        compare_all();
    endtask

    task automatic set_addr(input int s, input logic [15:0] a);
        bus.slot_addr[16*s +: 16] = a;
    endtask

    task automatic do_ack();
        bus.sdram_ack = 1'b1;
        step();
        bus.sdram_ack = 1'b0;
    endtask

    task automatic do_data(input logic [15:0] d);
        bus.data_rdy  = 1'b1;
        bus.data_read = d;
        step();
        bus.data_rdy  = 1'b0;
    endtask

    task automatic wait_req();
        int k = 0;
        while (!bus.sdram_req && k < 20) begin
            step();
            k++;
        end
        chk("req_within_budget", 64'(bus.sdram_req), 64'd1);
    endtask

    initial begin
        rst           = 1'b1;
        downloading   = 1'b0;
        bus.slot_cs   = '0;
        bus.slot_addr = '0;
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b0;
        bus.data_read = '0;
        m_valid = '0; m_busy = 0; m_acked = 0; m_req = 0; m_addr = '0; m_win = 0; m_treq = '0;
        for (int i = 0; i < 4; i++) begin
            m_tag[i]  = '0;
            m_data[i] = '0;
        end

        step();
        step();
        chk("reset_ok", 64'(bus.slot_ok), 64'd0);
        chk("reset_req", 64'(bus.sdram_req), 64'd0);
        chk("reset_addr", 64'(bus.sdram_addr), 64'd0);
        chk("reset_dout", bus.slot_dout, 64'd0);
        rst = 1'b0;

        // single miss on slot 3
        bus.slot_cs = 4'b1000;
        set_addr(3, 16'h1234);
        step();
        chk("miss_req", 64'(bus.sdram_req), 64'd1);
        chk("miss_addr", 64'(bus.sdram_addr), 64'h001234);
        step();
        do_ack();
        chk("ack_drops_req", 64'(bus.sdram_req), 64'd0);
        step();
        step();
        do_data(16'hBEEF);
        chk("fill_ok3", 64'(bus.slot_ok), 64'h8);
        chk("fill_dout3", 64'(bus.slot_dout[63:48]), 64'hBEEF);

        // repeat hit, then address change and simultaneous ack+data
        check_now();
        step();
        chk("hit_no_req", 64'(bus.sdram_req), 64'd0);
        set_addr(3, 16'h1235);
        check_now();
        chk("changed_addr_ok", 64'(bus.slot_ok), 64'd0);
        step();
        chk("changed_addr_req", 64'(bus.sdram_addr), 64'h001235);
        bus.sdram_ack = 1'b1;
        bus.data_rdy  = 1'b1;
        bus.data_read = 16'h5555;
        step();
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b0;
        chk("ackdata_ok3", 64'(bus.slot_ok), 64'h8);
        chk("ackdata_dout3", 64'(bus.slot_dout[63:48]), 64'h5555);
        step();
        chk("ackdata_idle", 64'(bus.sdram_req), 64'd0);

        // all four miss together
        set_addr(0, 16'h0100);
        set_addr(1, 16'h0002);
        set_addr(2, 16'h0020);
        set_addr(3, 16'h2000);
        bus.slot_cs = 4'b1111;
        step();
        chk("prio_slot0_addr", 64'(bus.sdram_addr), 64'h000100);
        do_ack();
        do_data(16'hA000);
        wait_req();
        chk("prio_slot1_addr", 64'(bus.sdram_addr), 64'h010002);
        do_ack();
        do_data(16'hA001);
        wait_req();
        chk("prio_slot2_wrap_addr", 64'(bus.sdram_addr), 64'h000010);
        do_ack();
        do_data(16'hA002);
        wait_req();
        chk("prio_slot3_addr", 64'(bus.sdram_addr), 64'h002000);
        do_ack();
        do_data(16'hA003);
        step();
        chk("prio_all_ok", 64'(bus.slot_ok), 64'hF);
        chk("prio_all_dout", bus.slot_dout, 64'hA003_A002_A001_A000);

        // address moves while the request is outstanding
        bus.slot_cs = 4'b0001;
        set_addr(0, 16'h0005);
        step();
        chk("move_req_addr", 64'(bus.sdram_addr), 64'h000005);
        set_addr(0, 16'h0006);
        do_ack();
        do_data(16'hAAAA);
        chk("move_stale_ok", 64'(bus.slot_ok), 64'd0);
        chk("move_stale_dout", 64'(bus.slot_dout[15:0]), 64'hAAAA);
        wait_req();
        chk("move_refetch_addr", 64'(bus.sdram_addr), 64'h000006);
        do_ack();
        do_data(16'h6666);
        chk("move_refetch_ok", 64'(bus.slot_ok), 64'h1);

        // download during WAIT_DATA
        set_addr(0, 16'h0007);
        step();
        do_ack();
        downloading = 1'b1;
        step();
        chk("dl_req", 64'(bus.sdram_req), 64'd0);
        chk("dl_ok", 64'(bus.slot_ok), 64'd0);
        step();
        downloading   = 1'b0;
        bus.data_rdy  = 1'b1;
        bus.data_read = 16'hDEAD;
        step();
        bus.data_rdy  = 1'b0;
        chk("dl_late_data_ignored", 64'(bus.slot_dout[15:0]), 64'h6666);
        chk("dl_refetch_req", 64'(bus.sdram_req), 64'd1);
        chk("dl_refetch_addr", 64'(bus.sdram_addr), 64'h000007);
        do_ack();
        do_data(16'h7777);
        chk("dl_refill_ok", 64'(bus.slot_ok), 64'h1);

        // reset in the middle of a transaction
        set_addr(0, 16'h0008);
        step();
        do_ack();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.data_rdy  = 1'b1;
        bus.data_read = 16'h1111;
        step();
        bus.data_rdy  = 1'b0;
        chk("rst_mid_dout", 64'(bus.slot_dout[15:0]), 64'h0);
        chk("rst_mid_refetch", 64'(bus.sdram_addr), 64'h000008);
        do_ack();
        do_data(16'h8888);
        chk("rst_mid_refill", 64'(bus.slot_dout[15:0]), 64'h8888);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
